lcd_nibble_receiver: RTL and testbench
======================================

LCD_NIBBLE_RECEIVER -- requirements
Module: lcd_nibble_receiver

Interface
REQ-001 SHALL have parameter EXEC_SHORT, default 2000, busy cycles after a data write or ordinary command.
REQ-002 SHALL have parameter EXEC_LONG, default 82000, busy cycles after Clear Display (0x01) or Return Home (0x02/0x03).
REQ-003 SHALL have parameter NIBBLE_TIMEOUT, default 1000, maximum cycles between the high-nibble and low-nibble strobes.
REQ-004 SHALL have port clk, input, 1, single system clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous, active-low reset (0 = reset asserted).
REQ-006 SHALL have port SF_D, input, 4, LCD data nibble bus.
REQ-007 SHALL have port LCD_E, input, 1, enable strobe; data is taken on its falling edge.
REQ-008 SHALL have port LCD_RS, input, 1, register select (0 = command, 1 = data).
REQ-009 SHALL have port LCD_RW, input, 1, read/write (0 = write).
REQ-010 SHALL have port rx_data, output, 8, last assembled byte.
REQ-011 SHALL have port rx_rs, output, 1, RS value of the last assembled byte.
REQ-012 SHALL have port rx_valid, output, 1, one-cycle pulse when a byte completes.
REQ-013 SHALL have port busy, output, 1, high while the modelled instruction is executing.
REQ-014 SHALL have port ddram_addr, output, 7, modelled DDRAM cursor address.
REQ-015 SHALL have port protocol_err, output, 1, one-cycle pulse on a protocol violation.

Function
REQ-016 SHALL pass LCD_E, LCD_RS, LCD_RW and SF_D through two synchronizer flops, then detect a falling edge of synchronized LCD_E.
REQ-017 SHALL ignore strobes with synchronized LCD_RW=1: no capture, no error.
REQ-018 SHALL implement three states:
- HI: waiting for the high nibble.
- LO: waiting for the low nibble.
- EXEC: busy countdown.
REQ-019 In HI, a write strobe SHALL store SF_D as rx_data[7:4] plus the RS value, then go to LO.
REQ-020 In LO, a write strobe with matching RS SHALL:
- store rx_data[3:0];
- pulse rx_valid;
- go to EXEC.
REQ-021 rx_valid SHALL rise on the 3rd rising clk edge after the edge that first samples LCD_E low on the second strobe.
REQ-022 In LO, an RS mismatch SHALL pulse protocol_err, discard the byte and return to HI.
REQ-023 If LO persists for NIBBLE_TIMEOUT cycles without a strobe, the block SHALL pulse protocol_err, discard the high nibble and return to HI.
REQ-024 busy SHALL assert on the same edge as rx_valid and stay high for exactly EXEC_LONG cycles (RS=0, byte 0x01..0x03) or EXEC_SHORT cycles (all other bytes), then the block returns to HI.
REQ-025 A write strobe during EXEC SHALL pulse protocol_err, be discarded, and leave the countdown unaffected.
REQ-026 rx_data and rx_rs SHALL hold their values until the next completed byte.
REQ-027 The busy counter SHALL be wide enough to hold EXEC_LONG without overflow.

Reset
REQ-028 While reset=0, the block SHALL be in HI with:
- rx_data=0x00;
- rx_rs, rx_valid, busy, protocol_err =0;
- ddram_addr=0x00;
- synchronizers cleared to 0.
REQ-029 Reset asserted mid-byte or mid-EXEC SHALL abort the operation immediately, with no rx_valid or protocol_err pulse.

Configuration
REQ-030 With LCD_RX_ADDR_TRACK_EN defined, ddram_addr SHALL update when a byte completes:
- RS=0 byte 1aaaaaaa: load aaaaaaa.
- RS=0 byte 0x01..0x03: load 0x00.
- RS=1 byte: increment, wrapping 0x27->0x40 and 0x67->0x00.
REQ-031 Without LCD_RX_ADDR_TRACK_EN, ddram_addr SHALL be constant 0x00 and no tracking logic is synthesized.

Verification
REQ-032 Strobes RS=1, nibbles 0x4 then 0x1 -> rx_data=0x41, rx_rs=1, rx_valid one cycle, busy high exactly 2000 cycles, ddram_addr 0x00->0x01 (with macro).
REQ-033 RS=0 byte 0x01 -> busy high exactly 82000 cycles, ddram_addr=0x00.
REQ-034 High nibble with RS=0, low nibble with RS=1 -> protocol_err pulse, no rx_valid, next strobe is treated as a high nibble.
REQ-035 Single strobe then 1000 idle cycles -> protocol_err pulse, state HI; a strobe during busy -> protocol_err pulse, busy length unchanged.
REQ-036 Set address 0xA7 then one data write -> ddram_addr 0x27 then 0x40; set 0xE7 then one data write -> ddram_addr 0x00.
REQ-037 Reset=0 asserted between the two nibbles and during busy -> all outputs at reset values immediately; a clean byte after release is received correctly.

Source files
------------

// File: rtl/lcd_nibble_receiver.sv
`default_nettype none
// ============================================================================
//  Module   : lcd_nibble_receiver
//  Purpose  : Receives 4-bit LCD write nibbles, assembles bytes and models
//             controller busy time. Option LCD_RX_ADDR_TRACK_EN adds a DDRAM
//             cursor address model.
//  Revision : 1.0
// ============================================================================
module lcd_nibble_receiver #(
    parameter int EXEC_SHORT     = 2000,
    parameter int EXEC_LONG      = 82000,
    parameter int NIBBLE_TIMEOUT = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] SF_D,
    input  logic       LCD_E,
    input  logic       LCD_RS,
    input  logic       LCD_RW,
    output logic [7:0] rx_data,
    output logic       rx_rs,
    output logic       rx_valid,
    output logic       busy,
    output logic [6:0] ddram_addr,
    output logic       protocol_err
);

    localparam int EXEC_MAX = (EXEC_LONG > EXEC_SHORT) ? EXEC_LONG : EXEC_SHORT;
    localparam int BW       = (EXEC_MAX > 1) ? $clog2(EXEC_MAX + 1) : 1;
    localparam int TW       = (NIBBLE_TIMEOUT > 1) ? $clog2(NIBBLE_TIMEOUT + 1) : 1;

    localparam logic [BW-1:0] c_short_load = BW'(EXEC_SHORT - 1);
    localparam logic [BW-1:0] c_long_load  = BW'(EXEC_LONG - 1);
    localparam logic [TW-1:0] c_to_last    = TW'(NIBBLE_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_HI   = 2'd0,
        S_LO   = 2'd1,
        S_EXEC = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_e_s1, r_e_s2, r_e_s3;
    logic        r_rs_s1, r_rs_s2;
    logic        r_rw_s1, r_rw_s2;
    logic [3:0]  r_d_s1, r_d_s2;
    logic        r_stb;
    logic        r_stb_rs;
    logic [3:0]  r_stb_d;
    logic [3:0]  r_hi;
    logic        r_hi_rs;
    logic [TW-1:0] r_tcnt;
    logic [BW-1:0] r_bcnt;

    logic [7:0]  w_byte;
    logic        w_complete;
    logic        w_long;

    // Two-flop synchronizers, then a registered write-strobe pulse so the
    // captured nibble and RS are aligned with it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_e_s1   <= 1'b0;
            r_e_s2   <= 1'b0;
            r_e_s3   <= 1'b0;
            r_rs_s1  <= 1'b0;
            r_rs_s2  <= 1'b0;
            r_rw_s1  <= 1'b0;
            r_rw_s2  <= 1'b0;
            r_d_s1   <= 4'h0;
            r_d_s2   <= 4'h0;
            r_stb    <= 1'b0;
            r_stb_rs <= 1'b0;
            r_stb_d  <= 4'h0;
        end else begin
            r_e_s1   <= LCD_E;
            r_e_s2   <= r_e_s1;
            r_e_s3   <= r_e_s2;
            r_rs_s1  <= LCD_RS;
            r_rs_s2  <= r_rs_s1;
            r_rw_s1  <= LCD_RW;
            r_rw_s2  <= r_rw_s1;
            r_d_s1   <= SF_D;
            r_d_s2   <= r_d_s1;
            r_stb    <= r_e_s3 & ~r_e_s2 & ~r_rw_s2;
            r_stb_rs <= r_rs_s2;
            r_stb_d  <= r_d_s2;
        end
    end

    assign w_byte     = {r_hi, r_stb_d};
    assign w_complete = (r_state == S_LO) && r_stb && (r_stb_rs == r_hi_rs);
    assign w_long     = ~r_stb_rs && (w_byte[7:2] == 6'd0) && (w_byte[1:0] != 2'd0);

    // The high nibble is held privately so rx_data only changes on a full byte.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_HI;
            r_hi         <= 4'h0;
            r_hi_rs      <= 1'b0;
            r_tcnt       <= '0;
            r_bcnt       <= '0;
            rx_data      <= 8'h00;
            rx_rs        <= 1'b0;
            rx_valid     <= 1'b0;
            busy         <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            rx_valid     <= 1'b0;
            protocol_err <= 1'b0;
            case (r_state)
                S_HI: begin
                    if (r_stb) begin
                        r_hi    <= r_stb_d;
                        r_hi_rs <= r_stb_rs;
                        r_tcnt  <= '0;
                        r_state <= S_LO;
                    end
                end
                S_LO: begin
                    if (w_complete) begin
                        rx_data  <= w_byte;
                        rx_rs    <= r_stb_rs;
                        rx_valid <= 1'b1;
                        busy     <= 1'b1;
                        r_bcnt   <= w_long ? c_long_load : c_short_load;
                        r_state  <= S_EXEC;
                    end else if (r_stb) begin
                        protocol_err <= 1'b1;
                        r_state      <= S_HI;
                    end else if (r_tcnt == c_to_last) begin
                        protocol_err <= 1'b1;
                        r_state      <= S_HI;
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                end
                S_EXEC: begin
                    if (r_stb) begin
                        protocol_err <= 1'b1;
                    end
                    if (r_bcnt == '0) begin
                        busy    <= 1'b0;
                        r_state <= S_HI;
                    end else begin
                        r_bcnt <= r_bcnt - 1'b1;
                    end
                end
                default: r_state <= S_HI;
            endcase
        end
    end

`ifdef LCD_RX_ADDR_TRACK_EN
    logic [6:0] r_addr;

    // Data writes advance within the two 40-character line windows.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_addr <= 7'h00;
        end else if (w_complete) begin
            if (!r_stb_rs) begin
                if (w_byte[7]) begin
                    r_addr <= w_byte[6:0];
                end else if (w_long) begin
                    r_addr <= 7'h00;
                end
            end else if (r_addr == 7'h27) begin
                r_addr <= 7'h40;
            end else if (r_addr == 7'h67) begin
                r_addr <= 7'h00;
            end else begin
                r_addr <= r_addr + 7'd1;
            end
        end
    end

    assign ddram_addr = r_addr;
`else
    assign ddram_addr = 7'h00;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lcd_nibble_receiver.sv
`default_nettype none
// Bench for lcd_nibble_receiver: byte-level reference model feeds a queue of
// expected events that a monitor checks against rx_valid / protocol_err / busy.
module tb_lcd_nibble_receiver;

    localparam int EXEC_SHORT     = 20;
    localparam int EXEC_LONG      = 60;
    localparam int NIBBLE_TIMEOUT = 30;
`ifdef LCD_RX_ADDR_TRACK_EN
    localparam bit TRACK = 1'b1;
`else
    localparam bit TRACK = 1'b0;
`endif

    logic       clk    = 1'b0;
    logic       reset  = 1'b0;
    logic [3:0] SF_D   = 4'h0;
    logic       LCD_E  = 1'b0;
    logic       LCD_RS = 1'b0;
    logic       LCD_RW = 1'b0;
    logic [7:0] rx_data;
    logic       rx_rs;
    logic       rx_valid;
    logic       busy;
    logic [6:0] ddram_addr;
    logic       protocol_err;

    lcd_nibble_receiver #(
        .EXEC_SHORT     (EXEC_SHORT),
        .EXEC_LONG      (EXEC_LONG),
        .NIBBLE_TIMEOUT (NIBBLE_TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .SF_D         (SF_D),
        .LCD_E        (LCD_E),
        .LCD_RS       (LCD_RS),
        .LCD_RW       (LCD_RW),
        .rx_data      (rx_data),
        .rx_rs        (rx_rs),
        .rx_valid     (rx_valid),
        .busy         (busy),
        .ddram_addr   (ddram_addr),
        .protocol_err (protocol_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
        logic       rs;
        logic [6:0] addr;
        int         blen;
    } exp_t;

    exp_t       q[$];
    logic [6:0] model_addr = 7'h00;
    int         vectors     = 0;
    int         miscompares = 0;
    int         exp_blen    = 0;
    int         busy_run    = 0;
    bit         busy_prev   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] next_addr(input logic rs, input logic [7:0] b,
                                             input logic [6:0] a);
        logic [6:0] t;
        if (!rs) begin
            if (b[7])                  t = b[6:0];
            else if (b >= 1 && b <= 3) t = 7'h00;
            else                       t = a;
        end else if (a == 7'h27) begin
            t = 7'h40;
        end else if (a == 7'h67) begin
            t = 7'h00;
        end else begin
            t = a + 7'd1;
        end
        return TRACK ? t : 7'h00;
    endfunction

    function automatic int busy_len(input logic rs, input logic [7:0] b);
        return (!rs && b >= 1 && b <= 3) ? EXEC_LONG : EXEC_SHORT;
    endfunction

    task automatic strobe(input logic rs, input logic [3:0] d, input logic rw);
        @(negedge clk);
        SF_D   = d;
        LCD_RS = rs;
        LCD_RW = rw;
        repeat (2) @(negedge clk);
        LCD_E = 1'b1;
        repeat (3) @(negedge clk);
        LCD_E = 1'b0;
        repeat (4) @(negedge clk);
        LCD_RW = 1'b0;
    endtask

    task automatic push_err();
        exp_t e;
        e.is_err = 1'b1;
        e.data   = 8'h00;
        e.rs     = 1'b0;
        e.addr   = 7'h00;
        e.blen   = 0;
        q.push_back(e);
    endtask

    task automatic send_byte(input logic rs, input logic [7:0] b);
        exp_t e;
        model_addr = next_addr(rs, b, model_addr);
        e.is_err   = 1'b0;
        e.data     = b;
        e.rs       = rs;
        e.addr     = model_addr;
        e.blen     = busy_len(rs, b);
        q.push_back(e);
        strobe(rs, b[7:4], 1'b0);
        strobe(rs, b[3:0], 1'b0);
    endtask

    task automatic xfer(input logic rs, input logic [7:0] b);
        send_byte(rs, b);
        repeat (busy_len(rs, b) + 6) @(negedge clk);
    endtask

    task automatic reset_pulse(input string name);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk(name, {17'd0, rx_data, rx_rs, rx_valid, busy, protocol_err, ddram_addr}, 32'd0);
        repeat (3) @(negedge clk);
        chk({name, "_held"}, {17'd0, rx_data, rx_rs, rx_valid, busy, protocol_err, ddram_addr}, 32'd0);
        model_addr = 7'h00;
        reset = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    // Monitor: pops one expectation per DUT event and measures busy width.
    always @(negedge clk) begin
        exp_t e;
        if (reset !== 1'b1) begin
            busy_prev = 1'b0;
            busy_run  = 0;
        end else begin
            if (rx_valid === 1'b1) begin
                if (q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_valid: got data 0x%0h with nothing expected", rx_data);
                end else begin
                    e = q.pop_front();
                    chk("kind_valid", {31'd0, e.is_err}, 32'd0);
                    chk("rx_data", {24'd0, rx_data}, {24'd0, e.data});
                    chk("rx_rs", {31'd0, rx_rs}, {31'd0, e.rs});
                    chk("ddram_addr", {25'd0, ddram_addr}, {25'd0, e.addr});
                    chk("busy_at_valid", {31'd0, busy}, 32'd1);
                    exp_blen = e.blen;
                end
            end
            if (protocol_err === 1'b1) begin
                if (q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_err: got protocol_err=1 required none");
                end else begin
                    e = q.pop_front();
                    chk("kind_err", {31'd0, e.is_err}, 32'd1);
                end
            end
            if (busy === 1'b1) begin
                busy_run++;
            end else if (busy_prev) begin
                chk("busy_len", busy_run, exp_blen);
                busy_run = 0;
            end
            busy_prev = (busy === 1'b1);
        end
    end

    initial begin
        logic       rs;
        logic [7:0] b;
        repeat (3) @(negedge clk);
        chk("reset_state", {17'd0, rx_data, rx_rs, rx_valid, busy, protocol_err, ddram_addr}, 32'd0);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        xfer(1'b1, 8'h41);
        xfer(1'b0, 8'h01);
        xfer(1'b0, 8'h02);
        xfer(1'b0, 8'h03);

        // RS mismatch between nibbles, then a clean byte
        push_err();
        strobe(1'b0, 4'h4, 1'b0);
        strobe(1'b1, 4'h1, 1'b0);
        repeat (5) @(negedge clk);
        xfer(1'b1, 8'h42);

        // lone high nibble times out
        push_err();
        strobe(1'b0, 4'h3, 1'b0);
        repeat (NIBBLE_TIMEOUT + 10) @(negedge clk);
        xfer(1'b1, 8'h5A);

        // write strobe during busy, then a read strobe during busy
        send_byte(1'b1, 8'h55);
        repeat (3) @(negedge clk);
        push_err();
        strobe(1'b0, 4'h9, 1'b0);
        repeat (EXEC_SHORT + 6) @(negedge clk);
        send_byte(1'b1, 8'h62);
        repeat (2) @(negedge clk);
        strobe(1'b1, 4'h0, 1'b1);
        repeat (EXEC_SHORT + 6) @(negedge clk);

        // read strobe while idle is ignored
        strobe(1'b0, 4'h8, 1'b1);
        xfer(1'b1, 8'h61);

        // address wrap points
        xfer(1'b0, 8'hA7);
        xfer(1'b1, 8'h30);
        xfer(1'b0, 8'hE7);
        xfer(1'b1, 8'h31);

        // reset between nibbles and during busy
        strobe(1'b1, 4'h7, 1'b0);
        reset_pulse("reset_mid_byte");
        xfer(1'b1, 8'h77);
        send_byte(1'b0, 8'h01);
        repeat (10) @(negedge clk);
        reset_pulse("reset_mid_exec");
        xfer(1'b1, 8'h78);

        for (int i = 0; i < 30; i++) begin
            rs = 1'($urandom_range(0, 1));
            b  = 8'($urandom);
            if ($urandom_range(0, 5) == 0) begin
                rs = 1'b0;
                b  = 8'($urandom_range(1, 3));
            end
            xfer(rs, b);
        end

        repeat (20) @(negedge clk);
        chk("queue_empty", q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
